// File: rtl/graf_pkg.sv
// graf_pkg: shared screen geometry, camera sentinel, framebuffer address width and pos_writer states
package graf_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam logic [9:0] CAM_INVALID = 10'h3FF;
  localparam int FB_ADDR_W = 19;
  typedef enum logic [2:0] {S_IDLE, S_ACC, S_SCALE, S_ADDR, S_REQ} pw_state_e;
endpackage

// File: rtl/pos_writer_pixel_scaler.sv
// pixel_scaler: registered ax/ay -> clamped (optionally mirrored) screen sx/sy at 5/8 scale; ports clk, reset, ax_i, ay_i, sx_o, sy_o
module pixel_scaler #(
  parameter bit MIRROR_X = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] ax_i,
  input  logic [9:0] ay_i,
  output logic [9:0] sx_o,
  output logic [8:0] sy_o
);
  import graf_pkg::*;
  logic [9:0] px, py, cx;
  logic [8:0] cy;
  always_comb begin
    px = 10'((13'(ax_i) * 13'd5) >> 3);
    py = 10'((13'(ay_i) * 13'd5) >> 3);
    cx = px > 10'(SCREEN_W - 1) ? 10'(SCREEN_W - 1) : px;
    cy = py > 10'(SCREEN_H - 1) ? 9'(SCREEN_H - 1) : py[8:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sx_o <= '0;
      sy_o <= '0;
    end else begin
      sx_o <= MIRROR_X ? 10'(SCREEN_W - 1) - cx : cx;
      sy_o <= cy;
    end
  end
endmodule

// File: rtl/pos_writer.sv
// pos_writer: averages camera blob samples into 640x480 framebuffer writes; ports clk, reset, x, y, pos_valid, wr_req/wr_addr/wr_data/wr_ack, pen_down, dropped
module pos_writer
  import graf_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter logic [DATA_W-1:0] COLOR  = 8'hFF,
  parameter int              AVG_LOG2 = 2,
  parameter bit              MIRROR_X = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 pos_valid,
  output logic                 wr_req,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  input  logic                 wr_ack,
  output logic                 pen_down,
  output logic [7:0]           dropped
);
  localparam int SW = 10 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  pw_state_e state_q;
  logic [SW-1:0] sum_x_q, sum_y_q;
  logic [CW-1:0] cnt_q;
  logic [9:0] sx;
  logic [8:0] sy;
  logic invalid, busy, last;
  assign invalid = x == CAM_INVALID || y == CAM_INVALID;
  assign busy = state_q == S_SCALE || state_q == S_ADDR || state_q == S_REQ;
  // sums and count are zero in S_IDLE, so idle and accumulate share one path
  assign last = cnt_q == CW'((1 << AVG_LOG2) - 1);
  pixel_scaler #(.MIRROR_X(MIRROR_X)) u_scaler (
    .clk  (clk),
    .reset(reset),
    .ax_i (10'(sum_x_q >> AVG_LOG2)),
    .ay_i (10'(sum_y_q >> AVG_LOG2)),
    .sx_o (sx),
    .sy_o (sy)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sum_x_q  <= '0;
      sum_y_q  <= '0;
      cnt_q    <= '0;
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      pen_down <= 1'b0;
      dropped  <= '0;
    end else begin
      if (pos_valid && busy && dropped != 8'hFF) dropped <= dropped + 8'd1;
      case (state_q)
        S_IDLE, S_ACC: if (pos_valid) begin
          if (invalid) begin
            sum_x_q  <= '0;
            sum_y_q  <= '0;
            cnt_q    <= '0;
            pen_down <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            sum_x_q <= sum_x_q + SW'(x);
            sum_y_q <= sum_y_q + SW'(y);
            cnt_q   <= cnt_q + CW'(1);
            state_q <= last ? S_SCALE : S_ACC;
          end
        end
        S_SCALE: state_q <= S_ADDR;
        S_ADDR: begin
          // sy*640 as (sy<<9)+(sy<<7)
          wr_addr <= FB_ADDR_W'({sy, 9'b0}) + FB_ADDR_W'({sy, 7'b0}) + FB_ADDR_W'(sx);
          wr_data <= COLOR;
          wr_req  <= 1'b1;
          state_q <= S_REQ;
        end
        S_REQ: if (wr_ack) begin
          wr_req   <= 1'b0;
          pen_down <= 1'b1;
          sum_x_q  <= '0;
          sum_y_q  <= '0;
          cnt_q    <= '0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pos_writer.sv
// tb_pos_writer: directed checks of pos_writer with a plain and a mirrored instance sharing stimulus
module tb_pos_writer;
  logic clk = 1'b0, reset = 1'b1, pos_valid = 1'b0, wr_ack = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic wr_req, wr_req_m, pen_down, pen_m;
  logic [18:0] wr_addr, wr_addr_m;
  logic [7:0] wr_data, wr_data_m, dropped, dropped_m;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pos_writer #(.MIRROR_X(1'b0)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .pos_valid(pos_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .pen_down(pen_down), .dropped(dropped)
  );
  pos_writer #(.MIRROR_X(1'b1)) dut_m (
    .clk(clk), .reset(reset), .x(x), .y(y), .pos_valid(pos_valid),
    .wr_req(wr_req_m), .wr_addr(wr_addr_m), .wr_data(wr_data_m), .wr_ack(wr_ack),
    .pen_down(pen_m), .dropped(dropped_m)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic strobe(input logic [9:0] sx, input logic [9:0] sy);
    @(negedge clk);
    x = sx;
    y = sy;
    pos_valid = 1'b1;
    @(negedge clk);
    pos_valid = 1'b0;
  endtask
  task automatic strobe4(input logic [9:0] sx, input logic [9:0] sy);
    repeat (4) strobe(sx, sy);
  endtask
  task automatic wait_req(input string tag);
    int n = 0;
    while (!wr_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(tag, wr_req, 1);
  endtask
  task automatic ack();
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", wr_req, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_pen", pen_down, 0);
    chk("rst_drop", dropped, 0);
    reset = 1'b0;
    ack();
    chk("idle_ack_ignored", wr_req, 0);
    strobe4(512, 384);
    chk("lat0", wr_req, 0);
    @(negedge clk);
    chk("lat1", wr_req, 0);
    @(negedge clk);
    chk("lat2", wr_req, 1);
    chk("center_addr", wr_addr, 153920);
    chk("center_data", wr_data, 8'hFF);
    chk("center_addr_mirror", wr_addr_m, 153919);
    chk("pen_before_ack", pen_down, 0);
    @(negedge clk);
    chk("req_held", wr_req, 1);
    ack();
    chk("req_drop_after_ack", wr_req, 0);
    chk("pen_after_ack", pen_down, 1);
    strobe4(1022, 767);
    wait_req("corner_req");
    chk("corner_addr", wr_addr, 307198);
    chk("corner_addr_mirror", wr_addr_m, 306561);
    ack();
    chk("first_cycle_ack", wr_req, 0);
    strobe4(0, 1000);
    wait_req("clampy_req");
    chk("clampy_addr", wr_addr, 306560);
    chk("clampy_addr_mirror", wr_addr_m, 307199);
    ack();
    strobe4(0, 0);
    wait_req("origin_req");
    chk("origin_addr", wr_addr, 0);
    chk("origin_addr_mirror", wr_addr_m, 639);
    ack();
    chk("origin_pen", pen_down, 1);
    strobe(100, 100);
    strobe(100, 100);
    strobe(1023, 50);
    chk("pen_up_invalid", pen_down, 0);
    chk("pen_up_invalid_mirror", pen_m, 0);
    strobe4(200, 200);
    wait_req("discard_req");
    chk("discard_addr", wr_addr, 80125);
    chk("discard_addr_mirror", wr_addr_m, 80514);
    ack();
    chk("discard_pen", pen_down, 1);
    chk("no_drops_yet", dropped, 0);
    strobe4(512, 384);
    wait_req("busy_req");
    repeat (5) strobe(300, 300);
    repeat (10) @(negedge clk);
    chk("busy_req_held", wr_req, 1);
    chk("busy_addr_held", wr_addr, 153920);
    chk("busy_drops", dropped, 5);
    wr_ack = 1'b1;
    x = 800;
    y = 600;
    pos_valid = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    chk("ack_cycle_req_low", wr_req, 0);
    chk("ack_cycle_strobe_dropped", dropped, 6);
    repeat (4) @(negedge clk);
    pos_valid = 1'b0;
    wait_req("after_ack_req");
    chk("after_ack_addr", wr_addr, 240500);
    chk("after_ack_addr_mirror", wr_addr_m, 240139);
    x = 5;
    y = 5;
    pos_valid = 1'b1;
    repeat (300) @(negedge clk);
    pos_valid = 1'b0;
    chk("drop_saturate", dropped, 255);
    chk("drop_saturate_mirror", dropped_m, 255);
    chk("sat_req_held", wr_req, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreq_rst_req", wr_req, 0);
    chk("midreq_rst_addr", wr_addr, 0);
    chk("midreq_rst_data", wr_data, 0);
    chk("midreq_rst_pen", pen_down, 0);
    chk("midreq_rst_drop", dropped, 0);
    chk("midreq_rst_data_mirror", wr_data_m, 0);
    reset = 1'b0;
    strobe4(200, 200);
    wait_req("post_rst_req");
    chk("post_rst_addr", wr_addr, 80125);
    ack();
    chk("post_rst_pen", pen_down, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
